// File: rtl/cache_fill_fsm.sv
// Miss handler for the 2-way set-associative cache: streams the 8 words of a
// missing block from pipelined main memory into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [15:0]           cache_data,
  output logic                  write_data_array,
  output logic                  write_tag_array
);

  localparam int WORD_W   = $clog2(WORDS_PER_BLOCK);
  localparam int OFFSET_W = WORD_W + 1;  // 16-bit words, byte addressed
  localparam int CNT_W    = $clog2(WORDS_PER_BLOCK + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      req_cnt;
  logic [CNT_W-1:0]      rcv_cnt;

  // Word address inside the block: only the offset field is summed, so the
  // last word of the top block stays at 0x..FE instead of carrying into the tag.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] blk,
    input logic [WORD_W-1:0]     idx
  );
    logic [OFFSET_W-1:0] off;
    off = blk[OFFSET_W-1:0] + {idx, 1'b0};
    return {blk[ADDR_WIDTH-1:OFFSET_W], off};
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= {miss_address[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (req_cnt < CNT_FULL) begin
            req_cnt <= req_cnt + CNT_ONE;
          end
          // Completion tracks returned words only, so memory latency is irrelevant.
          if (memory_data_valid) begin
            rcv_cnt <= rcv_cnt + CNT_ONE;
            if (rcv_cnt == CNT_LAST) begin
              state <= TAG;
            end
          end
        end
        TAG: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state; the write strobe follows the memory
  // valid in the same cycle so each returned word lands without extra buffering.
  // NOTE: every output gets a default at the top of always_comb so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    fsm_busy         = (state != IDLE) | miss_detected;
    mem_rd_en        = 1'b0;
    memory_address   = word_addr(base, req_cnt[WORD_W-1:0]);
    cache_address    = miss_address;
    cache_data       = memory_data;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      FILL: begin
        mem_rd_en        = (req_cnt < CNT_FULL);
        write_data_array = memory_data_valid;
        cache_address    = word_addr(base, rcv_cnt[WORD_W-1:0]);
      end
      TAG: begin
        write_tag_array = 1'b1;
        cache_address   = base;
      end
      default: begin
        cache_address = miss_address;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a per-fill timeline model derived from
// the miss cycle and the scripted memory-valid schedule, plus literal pin points.
module tb_cache_fill_fsm;

  typedef int vec_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic [15:0] cache_address;
  logic [15:0] cache_data;
  logic        write_data_array;
  logic        write_tag_array;

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .fsm_busy         (fsm_busy),
    .mem_rd_en        (mem_rd_en),
    .memory_address   (memory_address),
    .cache_address    (cache_address),
    .cache_data       (cache_data),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, written only by the stimulus process.
  logic        check_en = 1'b0;
  logic        e_busy, e_rd, e_wr, e_tag;
  logic [15:0] e_maddr, e_caddr, e_data;

  int rd_total = 0, wr_total = 0, tag_total = 0, busy_total = 0;
  int last_len;

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1)        rd_total++;
    if (write_data_array === 1'b1) wr_total++;
    if (write_tag_array === 1'b1)  tag_total++;
    if (fsm_busy === 1'b1)         busy_total++;
    if (check_en) begin
      check("fsm_busy", fsm_busy, e_busy);
      check("mem_rd_en", mem_rd_en, e_rd);
      if (e_rd) check("memory_address", memory_address, e_maddr);
      check("cache_address", cache_address, e_caddr);
      check("cache_data", cache_data, e_data);
      check("write_data_array", write_data_array, e_wr);
      check("write_tag_array", write_tag_array, e_tag);
    end
  end

  function automatic logic [15:0] dat(input logic [15:0] b, input int k);
    return (b ^ 16'h3C5A) + 16'(k * 16'h0111);
  endfunction

  // Word k valid at miss cycle + 1 + L + gap*k.
  function automatic vec_t mkv(input int lat, input int gap);
    vec_t v;
    for (int k = 0; k < 8; k++) v[k] = 1 + lat + gap * k;
    return v;
  endfunction

  task automatic idle_cycle(input logic [15:0] a, input logic v);
    @(posedge clk); #1;
    miss_detected     = 1'b0;
    miss_address      = a;
    memory_data_valid = v;
    memory_data       = 16'($urandom);
    e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_tag = 1'b0;
    e_caddr = a; e_data = memory_data; e_maddr = '0;
    check_en = 1'b1;
    @(negedge clk); #1;
  endtask

  // One fill, relative cycle 0 = miss seen in IDLE; ends on the TAG cycle.
  task automatic run_fill(input logic [15:0] a, input vec_t v, input logic [15:0] nxt,
                          input bit hold, input int lit);
    logic [15:0] b;
    int tt, rcv, k, rd0, wr0, tag0, busy0;
    b  = {a[15:4], 4'h0};
    tt = v[7] + 1;
    rd0 = rd_total; wr0 = wr_total; tag0 = tag_total; busy0 = busy_total;
    for (int t = 0; t <= tt; t++) begin
      @(posedge clk); #1;
      miss_detected = (t == 0) || hold;
      miss_address  = (t == 0) ? a : nxt;
      k = -1; rcv = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i] == t) k = i;
        if (v[i] < t)  rcv++;
      end
      memory_data_valid = (k >= 0);
      memory_data       = (k >= 0) ? dat(b, k) : 16'($urandom);
      e_busy  = 1'b1;
      e_rd    = (t >= 1 && t <= 8);
      e_maddr = b | 16'(2 * (t - 1));
      e_wr    = (k >= 0);
      e_tag   = (t == tt);
      e_data  = memory_data;
      if (t == 0)       e_caddr = a;
      else if (t == tt) e_caddr = b;
      else if (k >= 0)  e_caddr = b | 16'(2 * k);
      else              e_caddr = b | 16'(2 * rcv);
      check_en = 1'b1;
      @(negedge clk); #1;
      if (lit == 1) begin
        if (t == 1)  check("lit_first_req", memory_address, 16'h1230);
        if (t == 8)  check("lit_last_req", {15'd0, mem_rd_en, memory_address}, 32'h1123E);
        if (t == 5)  check("lit_first_wr", {15'd0, write_data_array, cache_address}, 32'h11230);
        if (t == 12) check("lit_last_wr", {15'd0, write_data_array, cache_address}, 32'h1123E);
        if (t == 13) check("lit_tag", {15'd0, write_tag_array, cache_address}, 32'h11230);
      end else if (lit == 2) begin
        if (t == 8)    check("lit_top_req", memory_address, 16'hFFFE);
        if (t == v[7]) check("lit_top_wr", cache_address, 16'hFFFE);
      end
    end
    check("rd_pulses", rd_total - rd0, 8);
    check("wr_pulses", wr_total - wr0, 8);
    check("tag_pulses", tag_total - tag0, 1);
    last_len = busy_total - busy0;
    check("fill_len", last_len, tt + 1);
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b1; miss_address = 16'hABCD;
    memory_data_valid = 1'b1; memory_data = 16'h0;
    #3;
    check("rst_busy_follows_miss", fsm_busy, 1'b1);
    check("rst_rd", mem_rd_en, 1'b0);
    check("rst_wr", write_data_array, 1'b0);
    check("rst_tag", write_tag_array, 1'b0);
    miss_detected = 1'b0;
    #1 check("rst_busy_low", fsm_busy, 1'b0);
    #18 rst_n = 1'b1;

    idle_cycle(16'hABCD, 1'b0);
    idle_cycle(16'h5678, 1'b1);   // spurious valid in IDLE
    idle_cycle(16'h5679, 1'b1);

    run_fill(16'h1234, mkv(4, 1), 16'h9999, 1'b0, 1);
    check("lit_len_l4", last_len, 14);
    idle_cycle(16'h2222, 1'b0);
    check("lit_busy_end", fsm_busy, 1'b0);

    run_fill(16'h0A5C, mkv(4, 2), 16'h7777, 1'b0, 0);   // gapped returns
    idle_cycle(16'h0A5C, 1'b0);

    run_fill(16'hFFFF, mkv(4, 1), 16'h0000, 1'b0, 2);   // top-of-memory block
    idle_cycle(16'h0000, 1'b1);

    run_fill(16'h3456, mkv(4, 1), 16'hBEEF, 1'b1, 0);   // miss held through TAG
    run_fill(16'hBEEF, mkv(3, 1), 16'h1111, 1'b0, 0);
    idle_cycle(16'h1111, 1'b0);

    run_fill(16'h8642, mkv(1, 1), 16'h0101, 1'b0, 0);
    check("lit_len_l1", last_len, 11);
    idle_cycle(16'h0101, 1'b0);
    run_fill(16'hC0DE, mkv(8, 1), 16'h0202, 1'b0, 0);
    check("lit_len_l8", last_len, 18);
    idle_cycle(16'h0202, 1'b0);

    // Asynchronous reset in the middle of a fill.
    check_en = 1'b0;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h4444; memory_data_valid = 1'b0;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h6060;
    @(posedge clk); #1;
    memory_data_valid = 1'b1;
    #1;
    check("midfill_rd", mem_rd_en, 1'b1);
    check("midfill_wr", write_data_array, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rd", mem_rd_en, 1'b0);
    check("abort_wr", write_data_array, 1'b0);
    check("abort_tag", write_tag_array, 1'b0);
    check("abort_busy", fsm_busy, 1'b0);
    check("abort_caddr", cache_address, 16'h6060);
    #3 rst_n = 1'b1;
    memory_data_valid = 1'b0;
    idle_cycle(16'h6060, 1'b0);
    idle_cycle(16'h6062, 1'b1);
    run_fill(16'h2468, mkv(2, 1), 16'h0303, 1'b0, 0);
    idle_cycle(16'h0303, 1'b0);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
